cpu_run_control: RTL and testbench

Synthesisable run-controller for the 16-bit CPU. It replaces free-running clock stimulus with gated execution. The CPU runs on the shared Clock and is driven by CpuEn (clock enable) and CpuReset from this block. The block sequences a CPU reset, then runs for a programmable cycle budget, in continuous or single-step mode. It stops on budget expiry, PC breakpoint, CPU halt or an external Stop, and reports the cause.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cycle_counter.sv | 35 +++
 rtl/cpu_run_control.sv | 157 +++++++++++++++
 tb/tb_cpu_run_control.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and defaults for the CPU run controller.
package cpu_pkg;

  localparam int unsigned CPU_CYCLE_W        = 16;
  localparam int unsigned CPU_PC_W           = 16;
  localparam int unsigned CPU_DEFAULT_BUDGET = 30;
  localparam int unsigned CPU_RESET_HOLD     = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_HOLD  = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_ONE  = 3'd4,
    ST_DONE      = 3'd5
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_BUDGET = 2'b01,
    CAUSE_BP     = 2'b10,
    CAUSE_HALT   = 2'b11
  } done_cause_e;

endpackage

// File: rtl/cycle_counter.sv
// Saturating up-counter with synchronous clear and an equals-limit flag.
module cycle_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count_q,
  output logic         at_limit_c
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_c = (count_q == limit);

endmodule

// File: rtl/cpu_run_control.sv
// Gated-execution run controller: resets the CPU, then runs it continuously or
// step by step until budget, breakpoint, halt or external stop.
module cpu_run_control
  import cpu_pkg::*;
#(
  parameter int unsigned CYCLE_W        = CPU_CYCLE_W,
  parameter int unsigned PC_W           = CPU_PC_W,
  parameter int unsigned DEFAULT_BUDGET = CPU_DEFAULT_BUDGET,
  parameter int unsigned RESET_HOLD     = CPU_RESET_HOLD
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic               StepMode,
  input  logic               StepReq,
  input  logic [CYCLE_W-1:0] Budget,
  input  logic               BpEnable,
  input  logic [PC_W-1:0]    BpAddr,
  input  logic [PC_W-1:0]    CpuPC,
  input  logic               CpuHalt,
  output logic               CpuReset,
  output logic               CpuEn,
  output logic [CYCLE_W-1:0] CycleCount,
  output logic [2:0]         State,
  output logic               Done,
  output logic [1:0]         DoneCause
);

  localparam int unsigned HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CYCLE_W-1:0] budget_q, budget_d;
  logic              done_q, done_d;
  done_cause_e       cause_q, cause_d;

  logic              cnt_clr_c;
  logic              cpu_en_c;
  logic              at_limit_c;
  logic              stop_c;
  done_cause_e       stop_cause_c;

  cycle_counter #(
    .W (CYCLE_W)
  ) u_cycle_counter (
    .clk        (Clock),
    .rst        (Reset),
    .clr        (cnt_clr_c),
    .en         (cpu_en_c),
    .limit      (budget_q),
    .count_q    (CycleCount),
    .at_limit_c (at_limit_c)
  );

  // Stop sources in priority order; the breakpoint matches before the instruction executes.
  always_comb begin
    stop_cause_c = CAUSE_NONE;
    if (CpuHalt) begin
      stop_cause_c = CAUSE_HALT;
    end else if (BpEnable && (CpuPC == BpAddr)) begin
      stop_cause_c = CAUSE_BP;
    end else if (Stop) begin
      stop_cause_c = CAUSE_HALT;
    end else if (at_limit_c) begin
      stop_cause_c = CAUSE_BUDGET;
    end
    stop_c = (stop_cause_c != CAUSE_NONE);
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    budget_d  = budget_q;
    done_d    = done_q;
    cause_d   = cause_q;
    cnt_clr_c = 1'b0;
    cpu_en_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d   = ST_RST_HOLD;
          cnt_clr_c = 1'b1;
          done_d    = 1'b0;
          cause_d   = CAUSE_NONE;
          budget_d  = (Budget == '0) ? CYCLE_W'(DEFAULT_BUDGET) : Budget;
          hold_d    = HOLD_W'(RESET_HOLD);
        end
      end
      ST_RST_HOLD: begin
        if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = StepMode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (stop_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cause_d = stop_cause_c;
        end else if (StepMode) begin
          state_d = ST_STEP_WAIT;
        end else begin
          cpu_en_c = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (Stop) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cause_d = CAUSE_HALT;
        end else if (StepReq) begin
          state_d = ST_STEP_ONE;
        end else if (!StepMode) begin
          state_d = ST_RUN;
        end
      end
      ST_STEP_ONE: begin
        if (stop_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cause_d = stop_cause_c;
        end else begin
          cpu_en_c = 1'b1;
          state_d  = ST_STEP_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      budget_q <= CYCLE_W'(DEFAULT_BUDGET);
      done_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      budget_q <= budget_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
    end
  end

  // The CPU is held in reset alongside the system, and never enabled while Reset is high.
  assign CpuReset  = Reset || (state_q == ST_RST_HOLD);
  assign CpuEn     = cpu_en_c && !Reset;
  assign State     = state_q;
  assign Done      = done_q;
  assign DoneCause = cause_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Bench for cpu_run_control: vector table of complete runs plus hand sequences.
module tb_cpu_run_control;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        Stop;
  logic        StepMode;
  logic        StepReq;
  logic [15:0] Budget;
  logic        BpEnable;
  logic [15:0] BpAddr;
  logic [15:0] CpuPC;
  logic        CpuHalt;
  logic        CpuReset;
  logic        CpuEn;
  logic [15:0] CycleCount;
  logic [2:0]  State;
  logic        Done;
  logic [1:0]  DoneCause;

  cpu_run_control dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Stop       (Stop),
    .StepMode   (StepMode),
    .StepReq    (StepReq),
    .Budget     (Budget),
    .BpEnable   (BpEnable),
    .BpAddr     (BpAddr),
    .CpuPC      (CpuPC),
    .CpuHalt    (CpuHalt),
    .CpuReset   (CpuReset),
    .CpuEn      (CpuEn),
    .CycleCount (CycleCount),
    .State      (State),
    .Done       (Done),
    .DoneCause  (DoneCause)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] budget;
    logic        step;
    logic        bp_en;
    logic [15:0] bp_addr;
    int          halt_at;
    int          stop_at;
    logic [15:0] exp_count;
    logic [1:0]  exp_cause;
  } vec_t;

  typedef struct packed {
    logic [15:0] count;
    logic [1:0]  cause;
  } exp_t;

  localparam int NUM_VEC = 9;

  vec_t vecs [NUM_VEC];
  exp_t sb_q [$];
  exp_t exp_r;

  int n_cmp = 0;
  int n_bad = 0;
  int pc, halt_at, stop_at;
  int en_cnt, rst_cnt;
  logic en_seen;

  function automatic vec_t mk(logic [15:0] budget, logic step, logic bp_en, logic [15:0] bp_addr,
                              int halt_at_i, int stop_at_i, logic [15:0] cnt, logic [1:0] cause);
    vec_t v;
    v.budget = budget; v.step = step; v.bp_en = bp_en; v.bp_addr = bp_addr;
    v.halt_at = halt_at_i; v.stop_at = stop_at_i; v.exp_count = cnt; v.exp_cause = cause;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CPU model: PC advances on every enabled cycle; halt/stop fire at a chosen PC.
  task automatic apply_cpu();
    CpuPC   = 16'(pc);
    CpuHalt = (halt_at >= 0) && (pc == halt_at);
    Stop    = (stop_at >= 0) && (pc == stop_at);
  endtask

  task automatic tick();
    @(negedge Clock);
    en_seen = CpuEn;
    if (CpuEn === 1'b1) en_cnt++;
    if (CpuReset === 1'b1) rst_cnt++;
    @(posedge Clock);
    #1;
    if (en_seen === 1'b1) pc++;
    apply_cpu();
    Start   = 1'b0;
    StepReq = 1'b0;
  endtask

  task automatic start_run();
    pc      = 0;
    en_cnt  = 0;
    rst_cnt = 0;
    apply_cpu();
    Start = 1'b1;
    tick();
  endtask

  task automatic wait_done(int max_cycles);
    int g;
    g = 0;
    while (Done !== 1'b1 && g < max_cycles) begin
      tick();
      g++;
    end
    chk("done_reached", 32'(Done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; StepMode = 1'b0; StepReq = 1'b0;
    Budget = '0; BpEnable = 1'b0; BpAddr = '0; CpuPC = '0; CpuHalt = 1'b0;
    pc = 0; halt_at = -1; stop_at = -1; en_cnt = 0; rst_cnt = 0; en_seen = 1'b0;

    vecs[0] = mk(16'd0,   1'b0, 1'b0, 16'd0,  -1, -1, 16'd30, 2'b01);
    vecs[1] = mk(16'd100, 1'b0, 1'b1, 16'd8,  -1, -1, 16'd8,  2'b10);
    vecs[2] = mk(16'd50,  1'b0, 1'b0, 16'd0,  10, 10, 16'd10, 2'b11);
    vecs[3] = mk(16'd1,   1'b0, 1'b0, 16'd0,  -1, -1, 16'd1,  2'b01);
    vecs[4] = mk(16'd5,   1'b0, 1'b1, 16'd0,  -1, -1, 16'd0,  2'b10);
    vecs[5] = mk(16'd20,  1'b0, 1'b0, 16'd0,  -1,  3, 16'd3,  2'b11);
    vecs[6] = mk(16'd10,  1'b0, 1'b1, 16'd10, -1, -1, 16'd10, 2'b10);
    vecs[7] = mk(16'd12,  1'b0, 1'b1, 16'd5,   5, -1, 16'd5,  2'b11);
    vecs[8] = mk(16'd5,   1'b1, 1'b0, 16'd0,  -1,  0, 16'd0,  2'b11);

    // Reset state
    tick();
    tick();
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", 32'(CycleCount), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_cause", 32'(DoneCause), 32'd0);
    chk("rst_cpuen", 32'(CpuEn), 32'd0);
    chk("rst_cpureset", 32'(CpuReset), 32'd1);
    Reset = 1'b0;
    tick();
    chk("idle_cpureset", 32'(CpuReset), 32'd0);

    // Table of complete runs; Budget is scrambled after Start to show it is latched.
    for (int i = 0; i < NUM_VEC; i++) begin
      Budget   = vecs[i].budget;
      StepMode = vecs[i].step;
      BpEnable = vecs[i].bp_en;
      BpAddr   = vecs[i].bp_addr;
      halt_at  = vecs[i].halt_at;
      stop_at  = vecs[i].stop_at;
      sb_q.push_back('{count: vecs[i].exp_count, cause: vecs[i].exp_cause});
      start_run();
      Budget = 16'd3;
      wait_done(500);
      exp_r = sb_q.pop_front();
      chk($sformatf("v%0d_count", i), 32'(CycleCount), 32'(exp_r.count));
      chk($sformatf("v%0d_cause", i), 32'(DoneCause), 32'(exp_r.cause));
      chk($sformatf("v%0d_en_cycles", i), 32'(en_cnt), 32'(exp_r.count));
      chk($sformatf("v%0d_hold", i), 32'(rst_cnt), 32'd4);
      chk($sformatf("v%0d_state", i), 32'(State), 32'd5);
    end

    // Single-step: three pulses, then release into continuous run to the budget.
    Budget = 16'd5; StepMode = 1'b1; BpEnable = 1'b0; halt_at = -1; stop_at = -1;
    sb_q.push_back('{count: 16'd5, cause: 2'b01});
    start_run();
    for (int k = 0; k < 4; k++) tick();
    chk("step_wait_entry", 32'(State), 32'd3);
    for (int k = 0; k < 3; k++) begin
      StepReq = 1'b1;
      tick();
      tick();
    end
    chk("step_en_cycles", 32'(en_cnt), 32'd3);
    chk("step_count", 32'(CycleCount), 32'd3);
    chk("step_state", 32'(State), 32'd3);
    StepMode = 1'b0;
    wait_done(100);
    exp_r = sb_q.pop_front();
    chk("step_final_count", 32'(CycleCount), 32'(exp_r.count));
    chk("step_final_cause", 32'(DoneCause), 32'(exp_r.cause));
    chk("step_final_en", 32'(en_cnt), 32'(exp_r.count));

    // Restart from DONE, with Start pulses ignored in RST_HOLD and RUN.
    Budget = 16'd50;
    start_run();
    chk("restart_state", 32'(State), 32'd1);
    chk("restart_count", 32'(CycleCount), 32'd0);
    chk("restart_done", 32'(Done), 32'd0);
    chk("restart_cause", 32'(DoneCause), 32'd0);
    tick();
    Start = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_len", 32'(rst_cnt), 32'd4);
    chk("hold_to_run", 32'(State), 32'd2);
    for (int k = 0; k < 3; k++) tick();
    Start = 1'b1;
    tick();
    chk("run_start_ignored_count", 32'(CycleCount), 32'd4);
    chk("run_start_ignored_state", 32'(State), 32'd2);

    // Reset mid-run at CycleCount 7.
    begin
      int g;
      g = 0;
      while (CycleCount !== 16'd7 && g < 100) begin
        tick();
        g++;
      end
    end
    chk("midrun_count7", 32'(CycleCount), 32'd7);
    Reset = 1'b1;
    #1;
    chk("midrun_cpureset", 32'(CpuReset), 32'd1);
    chk("midrun_cpuen_gated", 32'(CpuEn), 32'd0);
    tick();
    chk("midrun_state", 32'(State), 32'd0);
    chk("midrun_count", 32'(CycleCount), 32'd0);
    chk("midrun_done", 32'(Done), 32'd0);
    chk("midrun_cause", 32'(DoneCause), 32'd0);
    #1;
    chk("midrun_cpuen", 32'(CpuEn), 32'd0);
    Reset = 1'b0;
    tick();
    chk("post_reset_state", 32'(State), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
